// File: rtl/seq_controller.sv
// Step sequencer transport controller: turns play/pause/stop commands into
// advance/clear pulses for a downstream step counter, plus a per-step gate.
module seq_controller #(
    parameter int DW    = 16,
    parameter int STEPS = 8
) (
    input  logic          clk,
    input  logic          rst,          // asynchronous, active-low
    input  logic          play,
    input  logic          pause,
    input  logic          stop,
    input  logic [DW-1:0] step_period,
    input  logic [DW-1:0] gate_len,
    output logic          advance,
    output logic          clear,
    output logic          gate,
    output logic          loop_pulse,
    output logic          running
);

    localparam int            IW         = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IW-1:0] LAST_STEP  = IW'(STEPS - 1);
    localparam logic [DW-1:0] MIN_PERIOD = DW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] timer_reg;
    logic [DW-1:0] period_reg;
    logic [IW-1:0] step_reg;
    logic          clear_reg;
    logic          rst_meta_reg;
    logic          rst_sync_reg;

    logic [DW-1:0] period_next;
    logic [IW-1:0] step_next;
    logic          at_last;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    // Periods below 2 would make advance fire every cycle; clamp them
    assign period_next = (step_period < MIN_PERIOD) ? MIN_PERIOD : step_period;
    assign step_next   = (step_reg == LAST_STEP) ? '0 : step_reg + IW'(1);
    assign at_last     = (timer_reg == period_reg - DW'(1));

    // A pause or stop in the last cycle of a step suppresses that advance, so
    // the downstream counter never sees an advance that the timer did not take
    assign advance    = (state_reg == RUN) && at_last && !stop && !pause;
    assign loop_pulse = advance && (step_reg == LAST_STEP);
    assign gate       = (state_reg == RUN) && (timer_reg < gate_len);
    assign running    = (state_reg == RUN);
    assign clear      = clear_reg;

    // Transport FSM: stop > pause > play, timer/step/period bookkeeping
    always_ff @(posedge clk or negedge rst_sync_reg) begin
        if (!rst_sync_reg) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            step_reg   <= '0;
            period_reg <= MIN_PERIOD;
            clear_reg  <= 1'b0;
        end else begin
            clear_reg <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                timer_reg <= '0;
                step_reg  <= '0;
                clear_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (play) begin
                            state_reg  <= RUN;
                            timer_reg  <= '0;
                            step_reg   <= '0;
                            period_reg <= period_next;
                            clear_reg  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // freeze timer, step and period exactly as they are
                            state_reg <= HOLD;
                        end else if (at_last) begin
                            timer_reg  <= '0;
                            step_reg   <= step_next;
                            period_reg <= period_next;
                        end else begin
                            timer_reg <= timer_reg + DW'(1);
                        end
                    end
                    HOLD: begin
                        if (play) begin
                            state_reg <= RUN;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter DW, default 16: width of the step_period, gate_len and internal step timer.
REQ-002 Parameter STEPS, default 8: sequence length in steps, mirroring the downstream step counter's wrap point.
REQ-003 Port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port play  in  1  start from stopped, or resume from paused; single-cycle pulse.
REQ-006 Port pause  in  1  freeze playback; single-cycle pulse.
REQ-007 Port stop  in  1  halt and return to step 0; single-cycle pulse.
REQ-008 Port step_period  in  DW  step length in clk cycles.
REQ-009 Port gate_len  in  DW  cycles per step the gate is high.
REQ-010 Port advance  out  1  one-cycle pulse that drives the step counter's enable.
REQ-011 Port clear  out  1  one-cycle pulse that drives the step counter's synchronous reset.
REQ-012 Port gate  out  1  note-on level for the current step.
REQ-013 Port loop_pulse  out  1  one-cycle pulse on the advance that wraps from step STEPS-1 to step 0.
REQ-014 Port running  out  1  high while in RUN.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-016 Command priority within a cycle SHALL be stop > pause > play; lower-priority commands in the same cycle are ignored.
REQ-017 IDLE + play SHALL, on the next edge: enter RUN, set timer=0, set step index=0, latch the period, and pulse clear for one cycle.
REQ-018 RUN + pause SHALL enter HOLD with timer, step index and latched period frozen; advance=0 and gate=0 throughout HOLD.
REQ-019 HOLD + play SHALL return to RUN and resume counting from the frozen timer value, with no clear pulse.
REQ-020 stop in RUN or HOLD SHALL enter IDLE, zero the timer and step index, and pulse clear for one cycle; stop in IDLE SHALL also pulse clear.
REQ-021 pause in IDLE or HOLD, and play in RUN, SHALL be ignored.
REQ-022 step_period SHALL be latched into period_q only at play-from-IDLE and on every advance cycle; changes at other times take effect at the next step boundary.
REQ-023 period_q values below 2 SHALL be clamped to 2.
REQ-024 In RUN, the timer SHALL increment each cycle.
REQ-025 When timer == period_q-1, the controller SHALL assert advance for that cycle and load timer=0 on the next edge.
REQ-026 The step interval between advance pulses SHALL therefore be exactly period_q cycles.
REQ-027 The internal step index SHALL increment on each advance, and SHALL wrap from STEPS-1 to 0 on that same advance.
REQ-028 loop_pulse SHALL be asserted coincident with the advance that performs the STEPS-1 to 0 wrap.
REQ-029 gate SHALL be combinationally equal to (state==RUN && timer < gate_len), using the live gate_len value.
REQ-030 gate_len=0 SHALL keep gate low for the whole step.
REQ-031 gate_len >= period_q SHALL hold gate high across step boundaries (legato).
REQ-032 advance and clear SHALL never be high in the same cycle.
REQ-033 running SHALL equal (state==RUN).

Reset
REQ-034 While rst is low: state=IDLE, timer=0, step index=0, period_q=2, and advance, clear, gate, loop_pulse and running all 0, independent of clk.
REQ-035 Reset deassertion SHALL be synchronized internally; the first active edge after release SHALL see state IDLE.
REQ-036 Reset asserted mid-RUN SHALL drop gate and running immediately, with no clear pulse generated.

Verification
REQ-037 Start/step timing: period=4, gate_len=2, play pulse -> clear pulse 1 cycle after play; gate high 2 of every 4 cycles; advance every 4th cycle, first when timer=3.
REQ-038 Loop wrap: STEPS=8, period=4, run 40 cycles -> 8th advance carries loop_pulse; only one loop_pulse per 32 cycles.
REQ-039 Pause/resume: pause at timer=2, hold 10 cycles, then play -> no advance and gate low during hold; next advance exactly 1 cycle after resume (timer 2 to 3); no clear.
REQ-040 Priority and stop: play+pause+stop in the same cycle while RUN -> IDLE, clear pulse, gate=0; a later play restarts with timer=0.
REQ-041 Boundary widths: period=1 -> advance every 2 cycles; gate_len=0 -> gate never high; gate_len=9 with period=4 -> gate constant high.
REQ-042 Period change and reset: step_period changed 4 -> 6 mid-step -> current step stays 4 cycles, next step 6; rst low mid-RUN -> all outputs 0 asynchronously.
